// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined zero-extend adder.
package adder_pkg;

  localparam int unsigned DEFAULT_CHUNK = 16;

  // Per-stage control record carried alongside each sum slice
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One carry-chain slice: adds a W-bit operand slice plus incoming carry and registers the result.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int unsigned W = DEFAULT_CHUNK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_in,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         valid
);

  localparam int unsigned WX = W + 1;

  logic [W:0]  add_c;
  stage_ctrl_t ctrl_q;

  assign add_c = WX'(a) + WX'(b) + WX'(cin);

  // Data only reloads for real tokens so the slice holds still across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      sum    <= '0;
    end else if (en) begin
      ctrl_q.valid <= valid_in;
      if (valid_in) begin
        ctrl_q.carry <= add_c[W];
        sum          <= add_c[W-1:0];
      end
    end
  end

  assign carry = ctrl_q.carry;
  assign valid = ctrl_q.valid;

endmodule

// File: rtl/pipelined_extend_adder.sv
// Pipelined a + zero_ext(b) with one register stage per CHUNK-bit carry slice and valid/ready flow.
// Define ADDER_CARRY_IN_EN to add a cin port summed in at stage 0.
module pipelined_extend_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH_A = 61,
  parameter int unsigned WIDTH_B = 1,
  parameter int unsigned CHUNK   = DEFAULT_CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
`ifdef ADDER_CARRY_IN_EN
  input  logic               cin,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A:0]   sum
);

  localparam int unsigned NUM_STAGES = num_stages(WIDTH_A, CHUNK);

  if (WIDTH_B > WIDTH_A || WIDTH_B < 1 || CHUNK < 1) begin : g_bad_cfg
    $error("pipelined_extend_adder: illegal WIDTH_B/CHUNK configuration");
  end

  logic                  carry0;
  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] c_q;
  logic [NUM_STAGES-1:0] en;
  logic [NUM_STAGES-1:0] adv;

`ifdef ADDER_CARRY_IN_EN
  assign carry0 = cin;
`else
  assign carry0 = 1'b0;
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;
    localparam int unsigned SW = (k == NUM_STAGES - 1) ? WIDTH_A - LO : CHUNK;
    localparam int unsigned PW = WIDTH_A - LO;

    // pa/pb: operand bits from this slice upward for the token entering this stage
    logic [PW-1:0]      pa;
    logic [PW-1:0]      pb;
    logic [LO+SW-1:0]   done;
    logic [SW-1:0]      s_q;
    logic               c_in;
    logic               v_in;

    assign en[k] = ~v_q[k] | adv[k];

    if (k == 0) begin : g_head
      assign pa   = a;
      assign pb   = PW'(b);
      assign v_in = in_valid;
      assign c_in = carry0;
      assign done = s_q;
    end else begin : g_body
      logic [LO-1:0] lo_q;

      // Pending operands ride with the token in stage k-1; completed slices with stage k
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pa <= '0;
          pb <= '0;
        end else if (en[k-1] && g_stage[k-1].v_in) begin
          pa <= g_stage[k-1].pa[PW+CHUNK-1:CHUNK];
          pb <= g_stage[k-1].pb[PW+CHUNK-1:CHUNK];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lo_q <= '0;
        end else if (en[k] && v_q[k-1]) begin
          lo_q <= g_stage[k-1].done;
        end
      end

      assign v_in = v_q[k-1];
      assign c_in = c_q[k-1];
      assign done = {s_q, lo_q};
    end

    if (k == NUM_STAGES - 1) begin : g_tail
      assign adv[k] = v_q[k] & out_ready;
    end else begin : g_mid
      assign adv[k] = v_q[k] & en[k+1];
    end

    adder_chunk_stage #(
      .W (SW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en[k]),
      .valid_in (v_in),
      .cin      (c_in),
      .a        (pa[SW-1:0]),
      .b        (pb[SW-1:0]),
      .sum      (s_q),
      .carry    (c_q[k]),
      .valid    (v_q[k])
    );
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[NUM_STAGES-1];
  assign sum       = {c_q[NUM_STAGES-1], g_stage[NUM_STAGES-1].done};

endmodule

// File: tb/tb_pipelined_extend_adder.sv
// Self-checking bench for pipelined_extend_adder: scoreboard of expected sums plus directed latency,
// backpressure, reset and ragged-slice checks. Honours ADDER_CARRY_IN_EN when defined.
module tb_pipelined_extend_adder;

  localparam int unsigned WA   = 61;
  localparam int unsigned WB   = 1;
  localparam int unsigned CH   = 16;
  localparam int unsigned NSTG = (WA + CH - 1) / CH;

  localparam int unsigned RWA  = 20;
  localparam int unsigned RWB  = 8;
  localparam int unsigned RCH  = 7;
  localparam int unsigned RNSTG = (RWA + RCH - 1) / RCH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [WA-1:0] a_d;
  logic [WB-1:0] b_d;
  logic          cin_d;
  logic [WA:0]   sum;

  logic           r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [RWA-1:0] r_a;
  logic [RWB-1:0] r_b;
  logic           r_cin;
  logic [RWA:0]   r_sum;

  always #5 clk = ~clk;

  pipelined_extend_adder #(.WIDTH_A(WA), .WIDTH_B(WB), .CHUNK(CH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_d),
    .b         (b_d),
`ifdef ADDER_CARRY_IN_EN
    .cin       (cin_d),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  pipelined_extend_adder #(.WIDTH_A(RWA), .WIDTH_B(RWB), .CHUNK(RCH)) u_rag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_in_valid),
    .in_ready  (r_in_ready),
    .a         (r_a),
    .b         (r_b),
`ifdef ADDER_CARRY_IN_EN
    .cin       (r_cin),
`endif
    .out_valid (r_out_valid),
    .out_ready (r_out_ready),
    .sum       (r_sum)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic last_in_ready;
  logic [WA:0] q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WA:0] ref_sum(input logic [WA-1:0] x, input logic [WB-1:0] y, input logic c);
    return (WA+1)'(x) + (WA+1)'(y) + (WA+1)'(c);
  endfunction

  task automatic rand_inputs();
    a_d = WA'({$urandom, $urandom});
    if ($urandom_range(0, 3) == 0) a_d = '1;
    b_d = WB'($urandom);
`ifdef ADDER_CARRY_IN_EN
    cin_d = 1'($urandom);
`endif
  endtask

  // One clock: check/score outputs and record transfers before the edge, return at edge+1
  task automatic cycle();
    @(negedge clk);
    if (q.size() == 0) check("no_stale_out_valid", 64'(out_valid), 64'(0));
    if (out_valid && q.size() > 0) begin
      check("sum_vs_model", 64'(sum), 64'(q[0]));
      if (out_ready) begin
        void'(q.pop_front());
        n_out++;
      end
    end
    last_in_ready = in_ready;
    if (in_valid && in_ready && !rst) begin
      q.push_back(ref_sum(a_d, b_d, cin_d));
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 60) begin
      cycle();
      k++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int lat, cyc0, acc0, out0;
    logic [RWA-1:0] ra_v [3];
    logic [RWB-1:0] rb_v [3];
    ra_v = '{20'hFFFFF, 20'h12345, 20'h00F80};
    rb_v = '{8'hFF, 8'hCB, 8'h80};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a_d = '0; b_d = '0; cin_d = 1'b0;
    r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_rag_in_ready", 64'(r_in_ready), 64'(1));
    rst = 1'b0;
    cycle();

    // All-ones + 1 carries through every slice
    a_d = '1; b_d = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(NSTG));
    check("t1_sum", 64'(sum), 64'h2000_0000_0000_0000);
    drain();

    // Back-to-back stream at full rate
    cyc0 = cyc; out0 = n_out;
    for (int i = 0; i < 16; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      cycle();
      check("t2_in_ready", 64'(last_in_ready), 64'(1));
    end
    in_valid = 1'b0;
    drain();
    check("t2_cycles", 64'(cyc - cyc0), 64'(16 + NSTG));
    check("t2_outputs", 64'(n_out - out0), 64'(16));

    // Backpressure fills the pipe, then releases
    out_ready = 1'b0; acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      cycle();
    end
    check("t3_accepted", 64'(n_acc - acc0), 64'(NSTG));
    check("t3_in_ready_low", 64'(in_ready), 64'(0));
    in_valid = 1'b0; out_ready = 1'b1; out0 = n_out;
    drain();
    check("t3_outputs", 64'(n_out - out0), 64'(NSTG));

    // Random valid/ready traffic
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with tokens in flight
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_rst_out_valid", 64'(out_valid), 64'(0));
    check("t4_rst_sum", 64'(sum), 64'(0));
    check("t4_rst_in_ready", 64'(in_ready), 64'(1));
    q.delete();
    cycle();
    cycle();
    rst = 1'b0;
    repeat (8) cycle();
    rand_inputs();
    in_valid = 1'b1; out0 = n_out;
    cycle();
    in_valid = 1'b0;
    drain();
    check("t4_post_reset_out", 64'(n_out - out0), 64'(1));

`ifdef ADDER_CARRY_IN_EN
    a_d = '0; b_d = '0; cin_d = 1'b1; in_valid = 1'b1;
    cycle();
    a_d = '1; b_d = '0; cin_d = 1'b1;
    cycle();
    in_valid = 1'b0; cin_d = 1'b0;
    drain();
`endif

    // Ragged final slice on the narrow instance
    for (int i = 0; i < 3; i++) begin
      r_a = ra_v[i]; r_b = rb_v[i]; r_in_valid = 1'b1;
      @(negedge clk);
      check("t5_in_ready", 64'(r_in_ready), 64'(1));
      @(posedge clk);
      #1;
      r_in_valid = 1'b0;
      lat = 1;
      while (!r_out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("t5_latency", 64'(lat), 64'(RNSTG));
      check("t5_sum", 64'(r_sum), 64'((RWA+1)'(ra_v[i]) + (RWA+1)'(rb_v[i])));
      if (i == 0) check("t5_sum_const", 64'(r_sum), 64'h1000FE);
      @(posedge clk);
      #1;
      check("t5_consumed", 64'(r_out_valid), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
